// File: rtl/slice_sequencer_pkg.sv
// spirose_drv_pkg: shared timing constants, address layout and sequencer state type
package spirose_drv_pkg;
  localparam int SEGMENT_CYCLES = 513;
  localparam int BLANKING_TIME = 72;
  localparam int DATA_CYCLES = SEGMENT_CYCLES - BLANKING_TIME;
  localparam int SEG_W = 10;
  localparam int SLICE_W = 7;
  localparam int MUX_W = 3;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 1 + SLICE_W + MUX_W + DATA_W;
  localparam int ROWS = 1 << MUX_W;
  typedef enum logic [1:0] {IDLE, WAIT_TURN, RUN} seq_state_t;
  typedef struct packed {
    logic bank;
    logic [SLICE_W-1:0] slice;
    logic [MUX_W-1:0] mux;
    logic [DATA_W-1:0] data_cycle;
  } fb_addr_t;
endpackage

// File: rtl/slice_sequencer_if.sv
// slice_sequencer_if: writer/driver control inputs and framebuffer/row-select outputs
interface slice_sequencer_if;
  import spirose_drv_pkg::*;
  logic enable;
  logic turn_sync;
  logic frame_ready;
  logic frame_consumed;
  logic framebuffer_sync;
  logic fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [ROWS-1:0] mux_out;
  logic fault;
  modport master(
    output enable, turn_sync, frame_ready,
    input frame_consumed, framebuffer_sync, fb_rd_en, fb_rd_addr, mux_out, fault
  );
  modport slave(
    input enable, turn_sync, frame_ready,
    output frame_consumed, framebuffer_sync, fb_rd_en, fb_rd_addr, mux_out, fault
  );
endinterface

// File: rtl/slice_sequencer_fb_addr_gen.sv
// fb_addr_gen: read strobe and address for the row displayed in the next segment
module fb_addr_gen import spirose_drv_pkg::*; #(
  parameter int NB_SLICES = 128,
  parameter int NB_MUX = 8
) (
  input logic run,
  input logic bank,
  input logic [SLICE_W-1:0] slice,
  input logic [MUX_W-1:0] mux,
  input logic [SEG_W-1:0] seg_cnt,
  output logic rd_en,
  output logic [ADDR_W-1:0] rd_addr
);
  logic last_mux;
  fb_addr_t addr;
  always_comb begin
    last_mux = mux == MUX_W'(NB_MUX - 1);
    rd_en = run && seg_cnt >= SEG_W'(BLANKING_TIME - 1) && seg_cnt < SEG_W'(BLANKING_TIME - 1 + DATA_CYCLES);
    addr.bank = bank;
    addr.mux = last_mux ? '0 : mux + 1'b1;
    addr.slice = !last_mux ? slice : slice == SLICE_W'(NB_SLICES - 1) ? '0 : slice + 1'b1;
    // RAM has one cycle of latency, so the fetch runs one cycle ahead of the shift phase
    addr.data_cycle = DATA_W'(seg_cnt + SEG_W'(1) - SEG_W'(BLANKING_TIME));
    rd_addr = rd_en ? addr : '0;
  end
endmodule

// File: rtl/slice_sequencer.sv
// slice_sequencer: rotation slice / mux-row timebase, framebuffer read scheduling,
// row select and turn-aligned framebuffer bank swap
module slice_sequencer import spirose_drv_pkg::*; #(
  parameter int NB_SLICES = 128,
  parameter int NB_MUX = 8,
  parameter int MISS_TURNS = 2
) (
  input logic clk_lse,
  input logic rst,
  slice_sequencer_if.slave bus
);
  seq_state_t state;
  logic [SEG_W-1:0] seg_cnt;
  logic [MUX_W-1:0] mux;
  logic [SLICE_W-1:0] slice;
  logic [3:0] miss_cnt;
  logic bank, pend, fault_q, consumed_q;
  logic run, last_seg, last_mux, last_slice, boundary, sync_now, new_turn, miss_hit;
  always_comb begin
    run = state == RUN;
    last_seg = seg_cnt == SEG_W'(SEGMENT_CYCLES - 1);
    last_mux = mux == MUX_W'(NB_MUX - 1);
    last_slice = slice == SLICE_W'(NB_SLICES - 1);
    boundary = run && last_seg && last_mux;
    sync_now = pend || bus.turn_sync;
    new_turn = sync_now || last_slice;
    miss_hit = !sync_now && last_slice && miss_cnt + 4'd1 >= 4'(MISS_TURNS);
  end
  always_ff @(posedge clk_lse or posedge rst)
    if (rst) begin
      state <= IDLE;
      seg_cnt <= '0;
      mux <= '0;
      slice <= '0;
      miss_cnt <= '0;
      bank <= 1'b0;
      pend <= 1'b0;
      fault_q <= 1'b0;
      consumed_q <= 1'b0;
    end else if (!bus.enable) begin
      state <= IDLE;
      seg_cnt <= '0;
      mux <= '0;
      slice <= '0;
      miss_cnt <= '0;
      pend <= 1'b0;
      fault_q <= 1'b0;
      consumed_q <= 1'b0;
    end else begin
      consumed_q <= 1'b0;
      case (state)
        IDLE: state <= WAIT_TURN;
        WAIT_TURN: if (bus.turn_sync) begin
          state <= RUN;
          fault_q <= 1'b0;
          miss_cnt <= '0;
          pend <= 1'b0;
        end
        RUN: begin
          seg_cnt <= last_seg ? '0 : seg_cnt + 1'b1;
          if (last_seg) mux <= last_mux ? '0 : mux + 1'b1;
          if (bus.turn_sync) begin
            pend <= 1'b1;
            miss_cnt <= '0;
          end
          // slice boundary: realign to turn_sync, count missed turns, swap banks only at slice 0
          if (boundary) begin
            pend <= 1'b0;
            if (miss_hit) begin
              state <= WAIT_TURN;
              fault_q <= 1'b1;
              seg_cnt <= '0;
              mux <= '0;
              slice <= '0;
              miss_cnt <= '0;
            end else begin
              slice <= new_turn ? '0 : slice + 1'b1;
              miss_cnt <= sync_now ? '0 : last_slice ? miss_cnt + 1'b1 : miss_cnt;
              if (new_turn && bus.frame_ready) begin
                bank <= ~bank;
                consumed_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  fb_addr_gen #(.NB_SLICES(NB_SLICES), .NB_MUX(NB_MUX)) u_addr (
    .run(run),
    .bank(bank),
    .slice(slice),
    .mux(mux),
    .seg_cnt(seg_cnt),
    .rd_en(bus.fb_rd_en),
    .rd_addr(bus.fb_rd_addr)
  );
  assign bus.framebuffer_sync = run && seg_cnt == '0 && mux == '0;
  // rows are dark during the segment's first cycle so the old row is off before the new one drives
  assign bus.mux_out = run && seg_cnt != '0 ? ROWS'(1) << mux : '0;
  assign bus.frame_consumed = consumed_q;
  assign bus.fault = fault_q;
endmodule

// File: tb/tb_slice_sequencer.sv
// tb_slice_sequencer: directed stimulus with queued expectations and an output monitor
module tb_slice_sequencer;
  localparam int SEG = 513;
  localparam int SL = 8 * SEG;
  localparam int TURN = 4 * SL;
  typedef struct { int c; string nm; logic [31:0] v; } probe_t;
  logic clk_lse = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  probe_t pq[$];
  int sync_q[$];
  int cons_q[$];
  probe_t p;
  logic [31:0] obs;
  int exp_c;
  int r, t1, t2, t3, r2, r3;
  slice_sequencer_if bus();
  slice_sequencer #(.NB_SLICES(4), .NB_MUX(8), .MISS_TURNS(2)) dut (
    .clk_lse(clk_lse),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk_lse = ~clk_lse;
  always @(posedge clk_lse) cyc <= cyc + 1;
  function automatic logic [19:0] a(logic b, int s, int m, int d);
    return {b, 7'(s), 3'(m), 9'(d)};
  endfunction
  function automatic logic [31:0] mk(logic f, logic c, logic s, logic e, logic [19:0] ad, logic [7:0] mo);
    return {f, c, s, e, ad, mo};
  endfunction
  task automatic probe(int c, string nm, logic [31:0] v);
    pq.push_back('{c, nm, v});
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_lse);
    #1;
  endtask
  task automatic tick_until(int c);
    while (cyc < c) tick();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.enable = 1'b0;
    bus.turn_sync = 1'b0;
    bus.frame_ready = 1'b0;
    fork
      forever begin
        @(negedge clk_lse);
        obs = {bus.fault, bus.frame_consumed, bus.framebuffer_sync, bus.fb_rd_en, bus.fb_rd_addr, bus.mux_out};
        while (pq.size() > 0 && pq[0].c <= cyc) begin
          p = pq.pop_front();
          chk(p.nm, obs, p.v);
        end
        if (bus.framebuffer_sync === 1'b1) begin
          exp_c = sync_q.size() > 0 ? sync_q.pop_front() : -1;
          chk("sync_cycle", cyc, exp_c);
        end
        if (bus.frame_consumed === 1'b1) begin
          exp_c = cons_q.size() > 0 ? cons_q.pop_front() : -1;
          chk("consumed_cycle", cyc, exp_c);
        end
      end
    join_none
    repeat (3) tick();
    probe(cyc, "reset_out", 0);
    tick();
    rst = 1'b0;
    bus.enable = 1'b1;
    bus.frame_ready = 1'b1;
    repeat (3) tick();
    probe(cyc, "wait_turn_out", 0);
    bus.turn_sync = 1'b1;
    r = cyc + 1;
    t1 = r + 3 * SL;
    t2 = t1 + TURN;
    t3 = t2 + TURN;
    probe(r, "first_sync", mk(0, 0, 1, 0, 0, 8'h00));
    probe(r + 1, "row0_on", mk(0, 0, 0, 0, 0, 8'h01));
    probe(r + 70, "blanking", mk(0, 0, 0, 0, 0, 8'h01));
    probe(r + 71, "rd_first", mk(0, 0, 0, 1, a(0, 0, 1, 0), 8'h01));
    probe(r + 511, "rd_last", mk(0, 0, 0, 1, a(0, 0, 1, 440), 8'h01));
    probe(r + 512, "pause", mk(0, 0, 0, 0, 0, 8'h01));
    probe(r + 513, "break_before_make", mk(0, 0, 0, 0, 0, 8'h00));
    probe(r + 514, "row1_on", mk(0, 0, 0, 0, 0, 8'h02));
    probe(r + SL, "slice1_sync", mk(0, 0, 1, 0, 0, 8'h00));
    probe(r + 2 * SL + 7 * SEG + 71, "s2m7_addr", mk(0, 0, 0, 1, a(0, 3, 0, 0), 8'h80));
    probe(t1 - 1, "s2_last_cycle", mk(0, 0, 0, 0, 0, 8'h80));
    probe(t1, "forced_wrap_swap", mk(0, 1, 1, 0, 0, 8'h00));
    probe(t1 + 1, "consume_single", mk(0, 0, 0, 0, 0, 8'h01));
    probe(t1 + 71, "bank1_addr", mk(0, 0, 0, 1, a(1, 0, 1, 0), 8'h01));
    probe(t1 + 3 * SL + 7 * SEG + 71, "s3m7_wrap_addr", mk(0, 0, 0, 1, a(1, 0, 0, 0), 8'h80));
    probe(t2, "wrap_no_ready", mk(0, 0, 1, 0, 0, 8'h00));
    probe(t2 + 71, "bank_held", mk(0, 0, 0, 1, a(1, 0, 1, 0), 8'h01));
    probe(t3 - 1, "pre_fault", mk(0, 0, 0, 0, 0, 8'h80));
    probe(t3, "fault_set", mk(1, 0, 0, 0, 0, 8'h00));
    probe(t3 + 5, "fault_sticky", mk(1, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 3; i++) sync_q.push_back(r + i * SL);
    for (int i = 0; i < 4; i++) sync_q.push_back(t1 + i * SL);
    for (int i = 0; i < 4; i++) sync_q.push_back(t2 + i * SL);
    cons_q.push_back(t1);
    tick();
    bus.turn_sync = 1'b0;
    tick_until(r + 9000);
    bus.turn_sync = 1'b1;
    tick();
    bus.turn_sync = 1'b0;
    tick_until(t1);
    bus.frame_ready = 1'b0;
    tick_until(t3 + 10);
    bus.turn_sync = 1'b1;
    r2 = cyc + 1;
    probe(r2, "resync_clears_fault", mk(0, 0, 1, 0, 0, 8'h00));
    probe(r2 + 1, "resync_row0", mk(0, 0, 0, 0, 0, 8'h01));
    probe(r2 + 2 * SEG + 299, "mid_run_addr", mk(0, 0, 0, 1, a(1, 0, 3, 228), 8'h04));
    probe(r2 + 2 * SEG + 300, "async_reset", 0);
    sync_q.push_back(r2);
    tick();
    bus.turn_sync = 1'b0;
    tick_until(r2 + 2 * SEG + 300);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    probe(cyc, "post_reset_idle", 0);
    repeat (2) tick();
    bus.enable = 1'b0;
    bus.turn_sync = 1'b1;
    probe(cyc + 1, "enable_wins", 0);
    probe(cyc + 2, "enable_wins_hold", 0);
    tick();
    bus.turn_sync = 1'b0;
    repeat (2) tick();
    bus.enable = 1'b1;
    repeat (2) tick();
    bus.turn_sync = 1'b1;
    r3 = cyc + 1;
    probe(r3, "restart_sync", mk(0, 0, 1, 0, 0, 8'h00));
    probe(r3 + 71, "bank_reset", mk(0, 0, 0, 1, a(0, 0, 1, 0), 8'h01));
    sync_q.push_back(r3);
    tick();
    bus.turn_sync = 1'b0;
    tick_until(r3 + 100);
    chk("probes_drained", pq.size(), 0);
    chk("syncs_drained", sync_q.size(), 0);
    chk("consumes_drained", cons_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
